// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and defaults for the pipeline issue arbiter.
package pipeline_ctrl_pkg;

  localparam int DATA_W_DEF     = 12;
  localparam int PIPE_DEPTH_DEF = 5;
  localparam int MAX_BURST_DEF  = 4;
  // Handshake cycle to response pulse, in cycles.
  localparam int RSP_LAT        = PIPE_DEPTH_DEF + 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic vld;
    logic id;
  } tag_t;

  // Round-robin pick: favour the requester that did not finish the last burst.
  function automatic logic rr_pick(input logic v0, input logic v1, input logic rr_last);
    if (v0 && v1) return ~rr_last;
    return v1;
  endfunction

endpackage

// File: rtl/pipeline_tag_shifter.sv
// Tag delay line: slot k holds the tag issued k edges earlier.
module pipeline_tag_shifter
  import pipeline_ctrl_pkg::*;
#(
  parameter int DEPTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  tag_t             tag_i,
  output logic [DEPTH-1:0] vld_o,
  output tag_t             last_o
);

  tag_t [DEPTH-1:0] slot_q;
  tag_t [DEPTH-1:0] slot_d;

  // Shift every cycle; new tag (or a bubble) enters slot 0.
  always_comb begin
    slot_d[0] = tag_i;
    for (int k = 1; k < DEPTH; k++) begin
      slot_d[k] = slot_q[k-1];
    end
  end

  // Slot registers; reset drops everything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) slot_q <= '0;
    else        slot_q <= slot_d;
  end

  // Per-slot valid view for enable hold and busy/drain decisions.
  always_comb begin
    vld_o = '0;
    for (int k = 0; k < DEPTH; k++) begin
      vld_o[k] = slot_q[k].vld;
    end
  end

  assign last_o = slot_q[DEPTH-1];

endmodule

// File: rtl/pipeline_issue_arbiter.sv
// Two-requester round-robin, burst-limited issue arbiter for the shared pipeline.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | nothing granted, no readies; picks a requester when any valid
// ST_SERVE | granted requester sees ready; counts handshakes toward burst
// ST_DRAIN | no readies; waits for new requests or for the tag pipe to empty
module pipeline_issue_arbiter
  import pipeline_ctrl_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int PIPE_DEPTH = PIPE_DEPTH_DEF,
  parameter int MAX_BURST  = MAX_BURST_DEF
) (
  input  logic              clk,
  input  logic              pon_rst_n_i,
  input  logic              req0_valid_i,
  input  logic [DATA_W-1:0] req0_data_i,
  output logic              req0_ready_o,
  input  logic              req1_valid_i,
  input  logic [DATA_W-1:0] req1_data_i,
  output logic              req1_ready_o,
  output logic [DATA_W-1:0] pipe_data_o,
  output logic              pipe_enable_o,
  input  logic [DATA_W-1:0] pipe_result_i,
  input  logic              pipe_valid_i,
  output logic              rsp0_valid_o,
  output logic              rsp1_valid_o,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic              busy_o,
  output logic              err_o
);

  // The result is on pipe_result_i while the tag sits in slot PIPE_DEPTH;
  // the response flop adds the final cycle of latency.
  localparam int TAG_SLOTS = PIPE_DEPTH + 1;
  localparam int BURST_W   = $clog2(MAX_BURST + 1);

  state_t               state_q, state_d;
  logic                 grant_q, grant_d;
  logic                 rr_last_q, rr_last_d;
  logic [BURST_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic [DATA_W-1:0]    pipe_data_q, pipe_data_d;
  logic                 pipe_enable_q, pipe_enable_d;
  logic                 rsp0_q, rsp0_d;
  logic                 rsp1_q, rsp1_d;
  logic [DATA_W-1:0]    rsp_data_q, rsp_data_d;
  logic                 err_q, err_d;

  logic                 issue;
  logic                 oth_valid;
  logic                 any_valid;
  logic                 pick;
  logic                 any_tag;
  logic [BURST_W-1:0]   burst_inc;
  tag_t                 tag_in;
  tag_t                 tag_last;
  logic [TAG_SLOTS-1:0] tag_vld;

  assign req0_ready_o = (state_q == ST_SERVE) && !grant_q;
  assign req1_ready_o = (state_q == ST_SERVE) &&  grant_q;

  assign issue     = (req0_valid_i & req0_ready_o) | (req1_valid_i & req1_ready_o);
  assign oth_valid = grant_q ? req0_valid_i : req1_valid_i;
  assign any_valid = req0_valid_i | req1_valid_i;
  assign pick      = rr_pick(req0_valid_i, req1_valid_i, rr_last_q);
  assign any_tag   = |tag_vld;
  assign burst_inc = burst_cnt_q + BURST_W'(1);
  assign tag_in    = '{vld: issue, id: grant_q};

  pipeline_tag_shifter #(
    .DEPTH (TAG_SLOTS)
  ) u_tags (
    .clk    (clk),
    .rst_n  (pon_rst_n_i),
    .tag_i  (tag_in),
    .vld_o  (tag_vld),
    .last_o (tag_last)
  );

  // Grant / burst / round-robin next-state.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_last_d   = rr_last_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (any_valid) begin
          grant_d     = pick;
          burst_cnt_d = '0;
          state_d     = ST_SERVE;
        end
      end
      ST_SERVE: begin
        if (issue) begin
          if (burst_inc == BURST_W'(MAX_BURST)) begin
            // Burst limit: hand over without a bubble if the other side waits.
            grant_d     = oth_valid ? ~grant_q : grant_q;
            burst_cnt_d = '0;
            rr_last_d   = grant_q;
          end else begin
            burst_cnt_d = burst_inc;
          end
        end else if (oth_valid) begin
          grant_d     = ~grant_q;
          burst_cnt_d = '0;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (any_valid) begin
          grant_d     = pick;
          burst_cnt_d = '0;
          state_d     = ST_SERVE;
        end else if (!any_tag) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pipeline drive, enable hold and response routing.
  always_comb begin
    pipe_data_d   = '0;
    pipe_enable_d = issue | (|tag_vld[PIPE_DEPTH-2:0]);
    rsp0_d        = 1'b0;
    rsp1_d        = 1'b0;
    rsp_data_d    = rsp_data_q;
    err_d         = err_q;
    if (issue) pipe_data_d = grant_q ? req1_data_i : req0_data_i;
    if (tag_last.vld) begin
      if (pipe_valid_i) begin
        rsp0_d     = ~tag_last.id;
        rsp1_d     =  tag_last.id;
        rsp_data_d = pipe_result_i;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge pon_rst_n_i) begin
    if (!pon_rst_n_i) begin
      state_q       <= ST_IDLE;
      grant_q       <= 1'b0;
      rr_last_q     <= 1'b1;
      burst_cnt_q   <= '0;
      pipe_data_q   <= '0;
      pipe_enable_q <= 1'b0;
      rsp0_q        <= 1'b0;
      rsp1_q        <= 1'b0;
      rsp_data_q    <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      rr_last_q     <= rr_last_d;
      burst_cnt_q   <= burst_cnt_d;
      pipe_data_q   <= pipe_data_d;
      pipe_enable_q <= pipe_enable_d;
      rsp0_q        <= rsp0_d;
      rsp1_q        <= rsp1_d;
      rsp_data_q    <= rsp_data_d;
      err_q         <= err_d;
    end
  end

  assign pipe_data_o   = pipe_data_q;
  assign pipe_enable_o = pipe_enable_q;
  assign rsp0_valid_o  = rsp0_q;
  assign rsp1_valid_o  = rsp1_q;
  assign rsp_data_o    = rsp_data_q;
  assign busy_o        = (state_q != ST_IDLE) | any_tag;
  assign err_o         = err_q;

endmodule
